chacha20_block_sched: RTL and testbench
=======================================

# chacha20_block_sched

Sequencing controller for the ChaCha20 block function. Owns the 16-word working state and drives four combinational quarter-round instances in parallel, alternating column and diagonal half-rounds one per clock. After the final feed-forward add it presents a 512-bit keystream block behind a valid/ready handshake. It sits between the key/nonce/counter source and the keystream consumer (XOR/encrypt stage).

## Interface
- ROUNDS, 20, number of half-round cycles; must be even and ≥2; 20 is standard ChaCha20, 8 and 12 are permitted.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries a valid key, nonce and counter.
- in_ready  out  1  block accepts a request; high only in IDLE.
- key  in  256  state words 4..11; word j is key[32j+31:32j].
- nonce  in  96  state words 13..15; word j is nonce[32j+31:32j].
- counter  in  32  state word 12.
- out_valid  out  1  keystream is valid and held stable.
- out_ready  in  1  consumer accepts the keystream.
- keystream  out  512  output word i is keystream[32i+31:32i].
- busy  out  1  high in ROUND or FINAL.

## Operation
- State words 0..3 are the constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: load the working state and a copy of the initial state, clear round_idx, go to ROUND.
- **ROUND**
  - Each cycle, working state ← result of one half-round, then round_idx+1.
  - Even round_idx is a column round: QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15).
  - Odd round_idx is a diagonal round: QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14).
  - When round_idx = ROUNDS-1 completes, go to FINAL.
- **FINAL**
  - keystream word i ← working[i] + initial[i], modulo 2^32 (carry discarded per word).
  - Set out_valid, go to DONE.
- **DONE**
  - Hold keystream and out_valid.
  - On out_ready: clear out_valid, go to IDLE.
- All four quarter rounds use the quarter-round datapath: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All arithmetic is 32-bit wrap-around.
- round_idx is wide enough to hold ROUNDS-1. It never exceeds ROUNDS-1.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, keystream=0, state IDLE.
- rst is checked first in every state. It aborts any in-flight block and discards it; no out_valid follows.
- Acceptance occurs at edge k when in_valid and in_ready are both high.
- ROUND occupies edges k+1..k+ROUNDS. FINAL occupies edge k+ROUNDS+1.
- out_valid is first visible after edge k+ROUNDS+1, i.e. ROUNDS+1 cycles after acceptance (21 for ROUNDS=20).
- in_ready is low from edge k until the out_ready handshake. in_valid during that window is ignored.
- out_ready may be high before out_valid. If it is high during FINAL, DONE still lasts at least one cycle.
- In DONE, a DONE→IDLE transition on edge m gives in_ready=1 after edge m. A new request accepted at edge m+1 gives the minimum throughput of one block per ROUNDS+3 cycles.
- keystream holds its value after the handshake until the next FINAL.
- Inputs are sampled only at the acceptance edge. Later changes have no effect on the block in progress.

## Test plan
- **RFC 8439 §2.3.2**
  - Stimulus: key words 0x03020100, 0x07060504, …, 0x1f1e1d1c; counter 1; nonce words 0x09000000, 0x4a000000, 0x00000000; out_ready held 1.
  - Response: out_valid exactly 21 cycles after acceptance; keystream words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3; word 15 = 4e3c50a2.
- **All-zero vector**
  - Stimulus: key=0, nonce=0, counter=0.
  - Response: keystream word 0 = 0xade0b876, word 1 = 0x903df1a0.
- **Backpressure**
  - Stimulus: out_ready low for 10 cycles after out_valid; toggle in_valid throughout.
  - Response: keystream stable, in_ready stays 0, no second acceptance; after out_ready pulses, in_ready=1 on the next cycle.
- **Reset mid-operation**
  - Stimulus: assert rst at round_idx=7.
  - Response: next cycle in_ready=1, busy=0, out_valid=0, keystream=0; a following request produces the correct RFC vector.
- **Back-to-back blocks**
  - Stimulus: counters 1 then 2, in_valid held high, out_ready held high.
  - Response: second acceptance occurs 23 cycles after the first; both keystreams match the reference model.
- **Wrap-around**
  - Stimulus: counter 0xffffffff and all key words 0xffffffff.
  - Response: keystream matches the software model bit-exactly (verifies per-word mod-2^32 feed-forward).

Source files
------------

// File: rtl/chacha20_block_sched.sv
// rtl/chacha20_block_sched.sv - ChaCha20 block sequencer: four parallel quarter rounds, one half-round per clock
module chacha20_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] ya,
  output logic [31:0] yb,
  output logic [31:0] yc,
  output logic [31:0] yd
);
  logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    a1 = a + b;
    d1 = d ^ a1;
    d1 = {d1[15:0], d1[31:16]};
    c1 = c + d1;
    b1 = b ^ c1;
    b1 = {b1[19:0], b1[31:20]};
    a2 = a1 + b1;
    d2 = d1 ^ a2;
    d2 = {d2[23:0], d2[31:24]};
    c2 = c1 + d2;
    b2 = b1 ^ c2;
    b2 = {b2[24:0], b2[31:25]};
    ya = a2;
    yb = b2;
    yc = c2;
    yd = d2;
  end
endmodule

module chacha20_block_sched #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);
  localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t          state, next_state;
  logic [RW-1:0]   round_idx;
  logic [31:0]     work [16];
  logic [31:0]     init [16];
  logic [31:0]     nxt  [16];
  logic [31:0]     qa [4], qb [4], qc [4], qd [4];
  logic [31:0]     ra [4], rb [4], rc [4], rd [4];
  logic            diag;
  logic            last_round;

  assign diag       = round_idx[0];
  assign last_round = (round_idx == RW'(ROUNDS - 1));

  // Diagonal rounds rotate the b/c/d rows by 1/2/3 lanes on the way in and back on the way out.
  for (genvar g = 0; g < 4; g++) begin : g_qr
    assign qa[g] = work[g];
    assign qb[g] = diag ? work[4 + ((g + 1) % 4)]  : work[4 + g];
    assign qc[g] = diag ? work[8 + ((g + 2) % 4)]  : work[8 + g];
    assign qd[g] = diag ? work[12 + ((g + 3) % 4)] : work[12 + g];

    chacha20_qr u_qr (
      .a (qa[g]), .b (qb[g]), .c (qc[g]), .d (qd[g]),
      .ya(ra[g]), .yb(rb[g]), .yc(rc[g]), .yd(rd[g])
    );

    assign nxt[g]      = ra[g];
    assign nxt[4 + g]  = diag ? rb[(g + 3) % 4] : rb[g];
    assign nxt[8 + g]  = diag ? rc[(g + 2) % 4] : rc[g];
    assign nxt[12 + g] = diag ? rd[(g + 1) % 4] : rd[g];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ROUND;
      ROUND:   if (last_round) next_state = FINAL;
      FINAL:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == ROUND) || (state == FINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      keystream <= '0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work[0]  <= 32'h61707865;
            work[1]  <= 32'h3320646e;
            work[2]  <= 32'h79622d32;
            work[3]  <= 32'h6b206574;
            init[0]  <= 32'h61707865;
            init[1]  <= 32'h3320646e;
            init[2]  <= 32'h79622d32;
            init[3]  <= 32'h6b206574;
            for (int j = 0; j < 8; j++) begin
              work[4 + j] <= key[32*j +: 32];
              init[4 + j] <= key[32*j +: 32];
            end
            work[12] <= counter;
            init[12] <= counter;
            for (int j = 0; j < 3; j++) begin
              work[13 + j] <= nonce[32*j +: 32];
              init[13 + j] <= nonce[32*j +: 32];
            end
            round_idx <= '0;
          end
        end
        ROUND: begin
          for (int j = 0; j < 16; j++) work[j] <= nxt[j];
          round_idx <= last_round ? '0 : round_idx + 1'b1;
        end
        FINAL: begin
          for (int j = 0; j < 16; j++) keystream[32*j +: 32] <= work[j] + init[j];
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha20_block_sched.sv
// tb/tb_chacha20_block_sched.sv - directed and randomized bench for chacha20_block_sched
module tb_chacha20_block_sched;
  localparam int ROUNDS = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] keystream;
  logic         busy;

  int checks = 0;
  int errors = 0;

  chacha20_block_sched #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .nonce(nonce), .counter(counter), .out_valid(out_valid),
    .out_ready(out_ready), .keystream(keystream), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4 + j] = k[32*j +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
    x = s;
    for (int r2 = 0; r2 < ROUNDS / 2; r2++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int j = 0; j < 16; j++) r[32*j +: 32] = x[j] + s[j];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits (bounded) for out_valid; lat = edges after acceptance.
  task automatic run_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           output int lat);
    key = k; nonce = n; counter = c; in_valid = 1'b1;
    check("ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("not_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] ks_hold, ks1, ks2, exp_ks;
  logic [255:0] k_r;
  logic [95:0]  n_r;
  logic [31:0]  c_r;
  int           lat, acc1, acc2, nks;
  logic         pre, ov_seen;

  initial begin
    for (int j = 0; j < 32; j++) rfc_key[8*j +: 8] = 8'(j);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; nonce = '0; counter = '0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_keystream", keystream, 0);

    // RFC 8439 2.3.2 with out_ready held high
    out_ready = 1'b1;
    run_block(rfc_key, rfc_nonce, 32'd1, lat);
    check("rfc_latency", lat, ROUNDS + 1);
    check("rfc_w0", keystream[31:0], 32'he4e7f110);
    check("rfc_w1", keystream[63:32], 32'h15593bd1);
    check("rfc_w2", keystream[95:64], 32'h1fdd0f50);
    check("rfc_w3", keystream[127:96], 32'hc47120a3);
    check("rfc_w15", keystream[511:480], 32'h4e3c50a2);
    check("rfc_model", keystream, ref_block(rfc_key, rfc_nonce, 32'd1));
    ks_hold = keystream;
    step();
    check("rfc_done_valid_clear", out_valid, 0);
    check("rfc_done_ready", in_ready, 1);
    check("rfc_hold_after_hs", keystream, ks_hold);

    // All-zero vector
    run_block('0, '0, 32'd0, lat);
    check("zero_w0", keystream[31:0], 32'hade0b876);
    check("zero_w1", keystream[63:32], 32'h903df1a0);
    check("zero_model", keystream, ref_block('0, '0, 32'd0));
    step();

    // Backpressure with in_valid toggling
    out_ready = 1'b0;
    k_r = rand256(); n_r = {$urandom, $urandom, $urandom}; c_r = $urandom;
    run_block(k_r, n_r, c_r, lat);
    check("bp_model", keystream, ref_block(k_r, n_r, c_r));
    ks_hold = keystream;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      key = rand256(); counter = $urandom;
      step();
      check("bp_valid_held", out_valid, 1);
      check("bp_not_ready", in_ready, 0);
      check("bp_ks_stable", keystream, ks_hold);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_ready_after_hs", in_ready, 1);
    check("bp_valid_after_hs", out_valid, 0);
    check("bp_ks_after_hs", keystream, ks_hold);
    step();
    check("bp_idle_stays", in_ready, 1);

    // Reset at round_idx = 7
    out_ready = 1'b1;
    key = rfc_key; nonce = rfc_nonce; counter = 32'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_in_ready", in_ready, 1);
    check("mid_busy_clr", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_keystream", keystream, 0);
    ov_seen = 1'b0;
    repeat (30) begin
      step();
      ov_seen = ov_seen | out_valid;
    end
    check("mid_no_valid", ov_seen, 0);
    run_block(rfc_key, rfc_nonce, 32'd1, lat);
    check("mid_rfc_latency", lat, ROUNDS + 1);
    check("mid_rfc_model", keystream, ref_block(rfc_key, rfc_nonce, 32'd1));
    step();

    // Back-to-back, in_valid and out_ready held high
    key = rfc_key; nonce = rfc_nonce; counter = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    acc1 = -1; acc2 = -1; nks = 0;
    for (int t = 1; t <= 120 && nks < 2; t++) begin
      pre = in_ready;
      step();
      if (pre && in_valid) begin
        if (acc1 < 0) begin
          acc1 = t; counter = 32'd2;
        end else if (acc2 < 0) begin
          acc2 = t; in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (nks == 0) ks1 = keystream;
        else ks2 = keystream;
        nks++;
      end
    end
    in_valid = 1'b0;
    check("b2b_blocks", nks, 2);
    check("b2b_spacing", acc2 - acc1, ROUNDS + 3);
    check("b2b_ks1", ks1, ref_block(rfc_key, rfc_nonce, 32'd1));
    check("b2b_ks2", ks2, ref_block(rfc_key, rfc_nonce, 32'd2));
    step();

    // Wrap-around of the feed-forward add
    n_r = {$urandom, $urandom, $urandom};
    run_block({256{1'b1}}, n_r, 32'hffffffff, lat);
    check("wrap_model", keystream, ref_block({256{1'b1}}, n_r, 32'hffffffff));
    step();

    // Random blocks
    for (int i = 0; i < 4; i++) begin
      k_r = rand256(); n_r = {$urandom, $urandom, $urandom}; c_r = $urandom;
      exp_ks = ref_block(k_r, n_r, c_r);
      run_block(k_r, n_r, c_r, lat);
      check("rand_latency", lat, ROUNDS + 1);
      check("rand_model", keystream, exp_ks);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
